cdc_handshake_tx: RTL and testbench



---
 rtl/cdc_handshake_tx.sv | 134 +++++++++++++
 tb/tb_cdc_handshake_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source side of a 4-phase req/ack clock-domain crossing.
//                Accepts one word in the local clk domain, holds it on
//                data_out and raises req_out until the foreign receiver
//                acknowledges. ack_in is synchronized internally.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                send_valid/send_data/send_ready - local accept handshake
//                req_out, data_out   - request and held word to far domain
//                ack_in              - asynchronous acknowledge (synchronized)
//                done                - one-cycle pulse on transfer completion
//                busy                - FSM not in IDLE
//                timeout_err         - sticky timeout flag, cleared by rst
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send_valid,
    input  logic [DATA_WIDTH-1:0] send_data,
    output logic                  send_ready,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic                  done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    // A zero timeout still needs a legal 1-bit counter; it simply never fires.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_sync;
    logic                   r_req;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_done;
    logic                   r_timeout;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   w_counting;
    logic [c_CNT_W-1:0]     w_cnt_inc;

    // ack_in is touched only by the first flop of this chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (send_valid)  w_state_next = c_REQ;
            c_REQ:     if (w_ack_sync)  w_state_next = c_RELEASE;
            c_RELEASE: if (!w_ack_sync) w_state_next = c_IDLE;
            default:                    w_state_next = c_IDLE;
        endcase
    end

    // Registered request, held data word and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_RELEASE) && !w_ack_sync;
            if ((r_state == c_IDLE) && send_valid) begin
                r_data <= send_data;
                r_req  <= 1'b1;
            end else if ((r_state == c_REQ) && w_ack_sync) begin
                r_req  <= 1'b0;
            end
        end
    end

    // Counter runs only while waiting on the far side and restarts on every
    // state change; the error flag is set on the edge the count lands on the
    // limit, and the FSM keeps waiting regardless.
    assign w_counting = (r_state != c_IDLE) && (w_state_next == r_state);
    assign w_cnt_inc  = r_cnt + c_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_counting) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= w_cnt_inc;
            end
            if ((TIMEOUT_CYCLES != 0) && w_counting &&
                (r_cnt != c_CNT_MAX) && (w_cnt_inc == c_CNT_MAX)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign send_ready  = (r_state == c_IDLE);
    assign busy        = !send_ready;
    assign req_out     = r_req;
    assign data_out    = r_data;
    assign done        = r_done;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_handshake_tx
//  Description : Directed self-checking bench for cdc_handshake_tx
//                (DATA_WIDTH=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    localparam int c_DW = 8;
    localparam int c_SS = 2;
    localparam int c_TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            send_valid;
    logic [c_DW-1:0] send_data;
    logic            send_ready;
    logic            req_out;
    logic [c_DW-1:0] data_out;
    logic            ack_in;
    logic            done;
    logic            busy;
    logic            timeout_err;

    // Receiver model: either a manual ack level or an echo of req_out
    // delayed by 0..4 clk cycles.
    logic       ack_man;
    logic       echo_en;
    int         echo_dly;
    logic [3:0] r_req_hist;
    int         done_cnt;
    int         n_chk;
    int         n_bad;

    always #5 clk = ~clk;

    always @(posedge clk) r_req_hist <= {r_req_hist[2:0], req_out};

    assign ack_in = !echo_en ? ack_man :
                    (echo_dly == 0) ? req_out : r_req_hist[echo_dly-1];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    cdc_handshake_tx #(
        .DATA_WIDTH     (c_DW),
        .SYNC_STAGES    (c_SS),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .send_valid  (send_valid),
        .send_data   (send_data),
        .send_ready  (send_ready),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!send_ready && n < 60) begin
            tick(1);
            n++;
        end
        chk(tag, {31'd0, send_ready}, 32'd1);
    endtask

    int d0;

    initial begin
        n_chk      = 0;
        n_bad      = 0;
        done_cnt   = 0;
        r_req_hist = '0;
        rst        = 1'b1;
        send_valid = 1'b0;
        send_data  = '0;
        ack_man    = 1'b1;
        echo_en    = 1'b0;
        echo_dly   = 0;

        // ---------------- reset with ack_in high ----------------
        tick(2);
        chk("rst_req",   {31'd0, req_out},     32'd0);
        chk("rst_data",  {24'd0, data_out},    32'd0);
        chk("rst_done",  {31'd0, done},        32'd0);
        chk("rst_ready", {31'd0, send_ready},  32'd1);
        chk("rst_busy",  {31'd0, busy},        32'd0);
        chk("rst_tmo",   {31'd0, timeout_err}, 32'd0);
        rst     = 1'b0;
        ack_man = 1'b0;
        tick(4);

        // ---------------- single transfer, echo after 3 cycles ----------------
        echo_en  = 1'b1;
        echo_dly = 3;
        d0       = done_cnt;
        send_valid = 1'b1;
        send_data  = 8'hA5;
        tick(1);                         // accept edge A0
        send_valid = 1'b0;
        send_data  = 8'h00;
        chk("s_req_up",  {31'd0, req_out}, 32'd1);
        chk("s_data",    {24'd0, data_out}, 32'hA5);
        chk("s_busy",    {31'd0, busy},    32'd1);
        // ack_in rises after A3; req must still be up after A5 and drop at A6
        tick(5);
        chk("s_req_hold", {31'd0, req_out}, 32'd1);
        tick(1);
        chk("s_req_down", {31'd0, req_out}, 32'd0);
        chk("s_data_mid", {24'd0, data_out}, 32'hA5);
        // ack_in falls after A9; done after A12
        tick(5);
        chk("s_no_done_yet", {31'd0, done}, 32'd0);
        tick(1);
        chk("s_done",    {31'd0, done},     32'd1);
        chk("s_data_end", {24'd0, data_out}, 32'hA5);
        tick(1);
        chk("s_done_1cy", {31'd0, done},      32'd0);
        chk("s_ready",    {31'd0, send_ready}, 32'd1);
        chk("s_done_cnt", done_cnt - d0,       32'd1);

        // ---------------- back-to-back, zero-delay echo ----------------
        echo_dly = 0;
        tick(2);
        d0 = done_cnt;
        send_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            send_data = 8'(k);
            wait_ready("b2b_wait");
            tick(1);
            chk("b2b_data", {24'd0, data_out}, k);
            chk("b2b_req",  {31'd0, req_out},  32'd1);
            send_data = 8'hEE;           // not accepted while busy
            tick(2);
            chk("b2b_hold", {24'd0, data_out}, k);
        end
        send_valid = 1'b0;
        wait_ready("b2b_end");
        tick(1);
        chk("b2b_done_cnt", done_cnt - d0, 32'd3);
        chk("b2b_last",     {24'd0, data_out}, 32'h03);

        // ---------------- busy drop ----------------
        echo_en = 1'b0;
        ack_man = 1'b0;
        tick(2);
        d0 = done_cnt;
        send_valid = 1'b1;
        send_data  = 8'h3C;
        tick(1);
        send_valid = 1'b0;
        tick(2);
        send_valid = 1'b1;
        send_data  = 8'hFF;
        tick(1);
        send_valid = 1'b0;
        chk("bd_data", {24'd0, data_out}, 32'h3C);
        chk("bd_req",  {31'd0, req_out},  32'd1);
        ack_man = 1'b1;
        tick(4);
        chk("bd_req_down", {31'd0, req_out}, 32'd0);
        ack_man = 1'b0;
        tick(4);
        chk("bd_done_cnt", done_cnt - d0,      32'd1);
        chk("bd_ready",    {31'd0, send_ready}, 32'd1);
        chk("bd_data_end", {24'd0, data_out},   32'h3C);
        chk("bd_tmo",      {31'd0, timeout_err}, 32'd0);

        // ---------------- timeout in REQ ----------------
        d0 = done_cnt;
        send_valid = 1'b1;
        send_data  = 8'h77;
        tick(1);                         // enter REQ, count = 0
        send_valid = 1'b0;
        tick(c_TO - 1);
        chk("to_before", {31'd0, timeout_err}, 32'd0);
        tick(1);
        chk("to_set",    {31'd0, timeout_err}, 32'd1);
        chk("to_req",    {31'd0, req_out},     32'd1);
        tick(5);
        chk("to_wait",   {31'd0, req_out},     32'd1);
        ack_man = 1'b1;
        tick(4);
        chk("to_req_down", {31'd0, req_out}, 32'd0);
        ack_man = 1'b0;
        tick(4);
        chk("to_done_cnt", done_cnt - d0,        32'd1);
        chk("to_sticky",   {31'd0, timeout_err}, 32'd1);
        chk("to_ready",    {31'd0, send_ready},  32'd1);

        // ---------------- reset in RELEASE ----------------
        send_valid = 1'b1;
        send_data  = 8'h5A;
        tick(1);
        send_valid = 1'b0;
        ack_man    = 1'b1;
        tick(4);
        chk("mr_release", {31'd0, busy},    32'd1);
        chk("mr_req_low", {31'd0, req_out}, 32'd0);
        ack_man = 1'b0;
        d0  = done_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mr_req",   {31'd0, req_out},     32'd0);
        chk("mr_ready", {31'd0, send_ready},  32'd1);
        chk("mr_done",  {31'd0, done},        32'd0);
        chk("mr_tmo",   {31'd0, timeout_err}, 32'd0);
        chk("mr_data",  {24'd0, data_out},    32'd0);
        tick(5);
        chk("mr_no_done", done_cnt - d0, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
